addsub_arbiter: RTL and testbench
=================================

Name: addsub_arbiter

Overview:
- Shares one adder/subtractor datapath among N_REQ requesters.
- Each requester submits an op (add or sub) with operands A and B over a valid/ready handshake.
- The block arbitrates round-robin, drives the datapath load strobe and operands, and waits a fixed datapath latency.
- It then returns the selected result, tagged with the requester id, over a valid/ready response channel.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WIDTH, 8, operand width in bits.
- DP_LAT, 1, cycles from the dp_load cycle to valid dp_sum/dp_sub (>=1).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_op  in  N_REQ  per-requester op: 0=add, 1=sub.
- req_a  in  N_REQ*WIDTH  packed operand A; slice i belongs to requester i.
- req_b  in  N_REQ*WIDTH  packed operand B.
- dp_load  out  1  one-cycle load strobe to the datapath.
- dp_a  out  WIDTH  operand A to the datapath.
- dp_b  out  WIDTH  operand B to the datapath.
- dp_sum  in  WIDTH+1  datapath A+B, carry in MSB.
- dp_sub  in  WIDTH+1  datapath A-B, two's complement, borrow/sign in MSB.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  $clog2(N_REQ)  requester index of the result.
- resp_data  out  WIDTH+1  result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset low, asynchronous):
  - State=IDLE, rr_ptr=0, op/grant registers=0.
  - dp_load=0, dp_a=0, dp_b=0.
  - resp_valid=0, resp_id=0, resp_data=0, busy=0.
  - Any in-flight op is discarded; no response is ever produced for it.
- FSM IDLE -> LOAD -> WAIT -> RESP -> IDLE.
- IDLE:
  - g = first index with req_valid set, searching from rr_ptr upward with wrap-around.
  - req_ready[g]=1 combinationally in that cycle; handshake completes there.
  - On that edge, capture req_a[g], req_b[g], req_op[g] and g; go to LOAD.
  - No req_valid set: stay in IDLE, req_ready=0.
- req_ready is 0 in every state except IDLE.
- Requesters hold valid and data until ready; the grant is recomputed every IDLE cycle.
- LOAD: dp_load=1 for exactly one cycle; dp_a/dp_b drive the captured operands (registered, held until the next capture); counter=0; go to WAIT.
- WAIT:
  - Lasts exactly DP_LAT cycles.
  - At the end of the last WAIT cycle, register dp_sum (op=add) or dp_sub (op=sub) into resp_data and the captured g into resp_id.
  - Go to RESP.
- RESP:
  - resp_valid=1; resp_data and resp_id are stable until resp_ready.
  - On resp_valid&&resp_ready: rr_ptr=(g+1) mod N_REQ, resp_valid drops next cycle, go to IDLE.
- Latency: acceptance at cycle c gives resp_valid from cycle c+2+DP_LAT.
- Throughput: at most one op per 3+DP_LAT cycles.
- The block performs no arithmetic; it passes the datapath result through, width WIDTH+1, no truncation.
- rr_ptr advances only on response completion, so a stalled response does not change priority.

Decomposition:
- Package addsub_pkg:
  - op_e (OP_ADD=1'b0, OP_SUB=1'b1).
  - state_e (IDLE, LOAD, WAIT, RESP).
- Sub-module rr_arbiter:
  - Purely combinational.
  - Inputs: req[N_REQ], ptr.
  - Outputs: one-hot grant, grant index, any.
- The FSM, latency counter and registers live in addsub_arbiter.

Test Plan (WIDTH=8, N_REQ=4, DP_LAT=1 unless noted; bench models the datapath with a registered sum/sub):
- Single add: req0 add a=200, b=100 -> req_ready[0] for one cycle c; dp_load=1 at c+1 with dp_a=200, dp_b=100; resp_valid at c+3 with resp_data=9'd300, resp_id=0.
- Single sub: req2 sub a=5, b=9 -> resp_data=9'h1FC (-4), resp_id=2, same timing as the add case.
- Fairness: all four req_valid held high continuously -> accept order 0,1,2,3,0,1, one acceptance every 4 cycles.
- Backpressure: resp_ready low for 5 cycles in RESP -> resp_valid/resp_data/resp_id stable, req_ready stays 0. Raising resp_ready returns to IDLE next cycle, and the next grant goes to g+1.
- Reset mid-op:
  - Pull reset low during WAIT -> all outputs 0 immediately, with no clock edge needed.
  - After release, with req1 and req3 valid -> grant goes to req1 (rr_ptr=0), and no stale response appears.
- Latency parameter: DP_LAT=3 build, req3 add a=255, b=1 -> resp_valid at c+5 with resp_data=9'd256.

Source files
------------

// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_pkg
//  Description : Shared types for the add/sub arbiter: the operation code
//                carried with each request and the arbiter FSM states.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package addsub_pkg;

   // Operation requested by a client
   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // Arbiter sequencing states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_e;

endpackage
`default_nettype wire

// File: rtl/addsub_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_arbiter_if
//  Description : Bundle of the request, datapath and response signals of the
//                add/sub arbiter.
//  Ports       : req_valid/req_ready/req_op/req_a/req_b - per-requester
//                handshake and packed operands (slice i = requester i)
//                dp_load/dp_a/dp_b/dp_sum/dp_sub - shared datapath
//                resp_valid/resp_ready/resp_id/resp_data - result channel
//                busy - arbiter not idle
//                Modport slave = arbiter side, master = client/datapath side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface addsub_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8
);
   localparam int ID_W = $clog2(N_REQ);

   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ-1:0]       req_op;
   logic [N_REQ*WIDTH-1:0] req_a;
   logic [N_REQ*WIDTH-1:0] req_b;
   logic                   dp_load;
   logic [WIDTH-1:0]       dp_a;
   logic [WIDTH-1:0]       dp_b;
   logic [WIDTH:0]         dp_sum;
   logic [WIDTH:0]         dp_sub;
   logic                   resp_valid;
   logic                   resp_ready;
   logic [ID_W-1:0]        resp_id;
   logic [WIDTH:0]         resp_data;
   logic                   busy;

   modport slave (
      input  req_valid, req_op, req_a, req_b, dp_sum, dp_sub, resp_ready,
      output req_ready, dp_load, dp_a, dp_b, resp_valid, resp_id, resp_data, busy
   );

   modport master (
      output req_valid, req_op, req_a, req_b, dp_sum, dp_sub, resp_ready,
      input  req_ready, dp_load, dp_a, dp_b, resp_valid, resp_id, resp_data, busy
   );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Grants the first asserted
//                request found searching upward from i_ptr with wrap-around.
//  Ports       : i_req       - request vector
//                i_ptr       - index with highest priority
//                o_grant     - one-hot grant (zero when no request)
//                o_grant_idx - index of the granted request
//                o_any       - at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         i_req,
   input  logic [$clog2(N_REQ)-1:0] i_ptr,
   output logic [N_REQ-1:0]         o_grant,
   output logic [$clog2(N_REQ)-1:0] o_grant_idx,
   output logic                     o_any
);
   localparam int ID_W = $clog2(N_REQ);

   always_comb begin
      int pos;
      o_grant     = '0;
      o_grant_idx = '0;
      o_any       = 1'b0;
      pos         = 0;
      // Walk offsets from the pointer; the inner loop keeps every vector
      // index a constant so no variable-width index is needed.
      for (int k = 0; k < N_REQ; k++) begin
         pos = (int'(i_ptr) + k) % N_REQ;
         for (int i = 0; i < N_REQ; i++) begin
            if (!o_any && (pos == i) && i_req[i]) begin
               o_any       = 1'b1;
               o_grant[i]  = 1'b1;
               o_grant_idx = ID_W'(i);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/addsub_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_arbiter
//  Description : Shares one external add/sub datapath among N_REQ requesters.
//                Round-robin accept, one-cycle load strobe, fixed DP_LAT wait,
//                then a tagged result on a valid/ready response channel.
//  Ports       : clk   - rising-edge clock
//                reset - asynchronous active-low reset
//                bus   - addsub_arbiter_if.slave (requests, datapath, response)
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_arbiter
   import addsub_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int WIDTH  = 8,
   parameter int DP_LAT = 1
) (
   input  logic           clk,
   input  logic           reset,
   addsub_arbiter_if.slave bus
);
   localparam int ID_W  = $clog2(N_REQ);
   localparam int CNT_W = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DP_LAT - 1);
   localparam logic [ID_W-1:0]  c_ID_LAST  = ID_W'(N_REQ - 1);

   state_e            r_state;
   logic [ID_W-1:0]   r_ptr;
   logic [ID_W-1:0]   r_gid;
   op_e               r_op;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_dp_load;
   logic              r_resp_valid;
   logic [ID_W-1:0]   r_resp_id;
   logic [WIDTH:0]    r_resp_data;
   logic              r_busy;

   logic [N_REQ-1:0]  w_grant;
   logic [ID_W-1:0]   w_gidx;
   logic              w_any;
   logic              w_idle;
   logic [WIDTH-1:0]  w_a;
   logic [WIDTH-1:0]  w_b;
   op_e               w_op;

   rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_rr_arbiter (
      .i_req       (bus.req_valid),
      .i_ptr       (r_ptr),
      .o_grant     (w_grant),
      .o_grant_idx (w_gidx),
      .o_any       (w_any)
   );

   // Ready is held off while reset is asserted so no handshake can be
   // observed by a requester that the FSM will not act on.
   assign w_idle        = (r_state == IDLE) && reset;
   assign bus.req_ready = w_idle ? w_grant : '0;

   // One-hot mux of the granted requester's operands and op
   always_comb begin
      w_a  = '0;
      w_b  = '0;
      w_op = OP_ADD;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_grant[i]) begin
            w_a  = bus.req_a[i*WIDTH +: WIDTH];
            w_b  = bus.req_b[i*WIDTH +: WIDTH];
            w_op = op_e'(bus.req_op[i]);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_ptr        <= '0;
         r_gid        <= '0;
         r_op         <= OP_ADD;
         r_a          <= '0;
         r_b          <= '0;
         r_cnt        <= '0;
         r_dp_load    <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_id    <= '0;
         r_resp_data  <= '0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_a       <= w_a;
                  r_b       <= w_b;
                  r_op      <= w_op;
                  r_gid     <= w_gidx;
                  r_dp_load <= 1'b1;
                  r_busy    <= 1'b1;
                  r_state   <= LOAD;
               end
            end
            LOAD: begin
               r_dp_load <= 1'b0;
               r_cnt     <= '0;
               r_state   <= WAIT;
            end
            WAIT: begin
               if (r_cnt == c_CNT_LAST) begin
                  r_resp_data  <= (r_op == OP_SUB) ? bus.dp_sub : bus.dp_sum;
                  r_resp_id    <= r_gid;
                  r_resp_valid <= 1'b1;
                  r_state      <= RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RESP: begin
               // Priority moves only once the result is taken
               if (bus.resp_ready) begin
                  r_ptr        <= (r_gid == c_ID_LAST) ? '0 : r_gid + 1'b1;
                  r_resp_valid <= 1'b0;
                  r_busy       <= 1'b0;
                  r_state      <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.dp_load    = r_dp_load;
   assign bus.dp_a       = r_a;
   assign bus.dp_b       = r_b;
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_id    = r_resp_id;
   assign bus.resp_data  = r_resp_data;
   assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_addsub_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addsub_arbiter
//  Description : Self-checking bench for addsub_arbiter. Two instances share
//                clock and reset: one with DP_LAT=1 and one with DP_LAT=3.
//                Each has a registered add/sub datapath model behind it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_arbiter;
   localparam int N_REQ = 4;
   localparam int WIDTH = 8;
   localparam int ID_W  = 2;
   localparam logic [WIDTH:0] c_JUNK = 9'h1AA;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   vectors     = 0;
   int   miscompares = 0;
   int   model_ptr   = 0;

   // What each requester currently presents on bus1
   bit   op_q [N_REQ];
   int   a_q  [N_REQ];
   int   b_q  [N_REQ];

   always #5 clk = ~clk;

   addsub_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus1 ();
   addsub_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus3 ();

   addsub_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .DP_LAT(1)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   addsub_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .DP_LAT(3)) u_dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus3)
   );

   // Datapath models: result appears DP_LAT cycles after the load cycle,
   // junk otherwise so a mistimed capture is visible.
   logic [WIDTH:0] d1_sum, d1_sub;
   logic [WIDTH:0] d3_sum [3];
   logic [WIDTH:0] d3_sub [3];

   always @(posedge clk) begin
      if (bus1.dp_load) begin
         d1_sum <= {1'b0, bus1.dp_a} + {1'b0, bus1.dp_b};
         d1_sub <= {1'b0, bus1.dp_a} - {1'b0, bus1.dp_b};
      end else begin
         d1_sum <= c_JUNK;
         d1_sub <= ~c_JUNK;
      end
      if (bus3.dp_load) begin
         d3_sum[0] <= {1'b0, bus3.dp_a} + {1'b0, bus3.dp_b};
         d3_sub[0] <= {1'b0, bus3.dp_a} - {1'b0, bus3.dp_b};
      end else begin
         d3_sum[0] <= c_JUNK;
         d3_sub[0] <= ~c_JUNK;
      end
      d3_sum[1] <= d3_sum[0];
      d3_sum[2] <= d3_sum[1];
      d3_sub[1] <= d3_sub[0];
      d3_sub[2] <= d3_sub[1];
   end

   assign bus1.dp_sum = d1_sum;
   assign bus1.dp_sub = d1_sub;
   assign bus3.dp_sum = d3_sum[2];
   assign bus3.dp_sub = d3_sub[2];

   // ---------------- reference model ----------------
   function automatic logic [WIDTH:0] ref_result(bit op, int a, int b);
      int r;
      r = op ? (a - b) : (a + b);
      return r[WIDTH:0];
   endfunction

   function automatic int model_pick(logic [N_REQ-1:0] v);
      for (int k = 0; k < N_REQ; k++) begin
         int idx;
         idx = (model_ptr + k) % N_REQ;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [N_REQ-1:0] onehot(int g);
      logic [N_REQ-1:0] r;
      r = '0;
      if (g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic clear_reqs();
      bus1.req_valid = '0; bus1.req_op = '0; bus1.req_a = '0; bus1.req_b = '0;
      bus1.resp_ready = 1'b0;
      bus3.req_valid = '0; bus3.req_op = '0; bus3.req_a = '0; bus3.req_b = '0;
      bus3.resp_ready = 1'b0;
   endtask

   task automatic set_req1(input int i, input bit op, input int a, input int b);
      op_q[i] = op;
      a_q[i]  = a;
      b_q[i]  = b;
      bus1.req_valid[i] = 1'b1;
      bus1.req_op[i]    = op;
      bus1.req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
      bus1.req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #2 reset = 1'b0;
      bus1.req_valid = '1;
      #1;
      vectors++;
      if ({bus1.resp_valid, bus1.resp_id, bus1.resp_data, bus1.dp_load, bus1.dp_a, bus1.dp_b, bus1.busy,
           bus3.resp_valid, bus3.resp_id, bus3.resp_data, bus3.dp_load, bus3.dp_a, bus3.dp_b, bus3.busy} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got rv=%0b id=%0d data=%h load=%0b a=%h b=%h busy=%0b want all 0",
                  bus1.resp_valid, bus1.resp_id, bus1.resp_data, bus1.dp_load, bus1.dp_a, bus1.dp_b, bus1.busy);
      end
      vectors++;
      if (bus1.req_ready !== '0) begin
         miscompares++;
         $display("FAIL reset_req_ready: got %b want 0000", bus1.req_ready);
      end
      bus1.req_valid = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      model_ptr = 0;
   endtask

   task automatic test_single(input int idx, input bit op, input int a, input int b, input int stall);
      int g;
      logic [WIDTH:0] exp_d;
      @(negedge clk);
      set_req1(idx, op, a, b);
      #1;
      g     = model_pick(bus1.req_valid);
      exp_d = ref_result(op, a, b);
      vectors++;
      if (bus1.req_ready !== onehot(g)) begin
         miscompares++;
         $display("FAIL single_ready: got %b want %b", bus1.req_ready, onehot(g));
      end
      @(negedge clk);
      bus1.req_valid[idx] = 1'b0;
      #1;
      vectors++;
      if ({bus1.dp_load, bus1.dp_a, bus1.dp_b, bus1.busy, bus1.req_ready}
          !== {1'b1, WIDTH'(a), WIDTH'(b), 1'b1, {N_REQ{1'b0}}}) begin
         miscompares++;
         $display("FAIL single_load: got load=%0b a=%0d b=%0d busy=%0b rdy=%b want load=1 a=%0d b=%0d busy=1 rdy=0",
                  bus1.dp_load, bus1.dp_a, bus1.dp_b, bus1.busy, bus1.req_ready, a, b);
      end
      @(negedge clk);
      #1;
      vectors++;
      if ({bus1.dp_load, bus1.resp_valid, bus1.busy} !== 3'b001) begin
         miscompares++;
         $display("FAIL single_wait: got load=%0b rv=%0b busy=%0b want 0 0 1",
                  bus1.dp_load, bus1.resp_valid, bus1.busy);
      end
      for (int s = 0; s <= stall; s++) begin
         @(negedge clk);
         bus1.resp_ready = (s == stall);
         #1;
         vectors++;
         if ({bus1.resp_valid, bus1.resp_id, bus1.resp_data, bus1.req_ready, bus1.busy}
             !== {1'b1, ID_W'(g), exp_d, {N_REQ{1'b0}}, 1'b1}) begin
            miscompares++;
            $display("FAIL single_resp[%0d]: got rv=%0b id=%0d data=%h rdy=%b want rv=1 id=%0d data=%h rdy=0",
                     s, bus1.resp_valid, bus1.resp_id, bus1.resp_data, bus1.req_ready, g, exp_d);
         end
      end
      @(negedge clk);
      bus1.resp_ready = 1'b0;
      #1;
      vectors++;
      if ({bus1.resp_valid, bus1.busy} !== 2'b00) begin
         miscompares++;
         $display("FAIL single_done: got rv=%0b busy=%0b want 0 0", bus1.resp_valid, bus1.busy);
      end
      model_ptr = (g + 1) % N_REQ;
   endtask

   task automatic test_fairness();
      int order [6] = '{0, 1, 2, 3, 0, 1};
      logic [WIDTH:0] exp_d;
      logic [N_REQ-1:0] exp_rdy;
      exp_d = '0;
      @(negedge clk);
      for (int i = 0; i < N_REQ; i++)
         set_req1(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      bus1.resp_ready = 1'b1;
      for (int n = 0; n < 6; n++) begin
         for (int k = 0; k < 4; k++) begin
            #1;
            exp_rdy = (k == 0) ? onehot(order[n]) : '0;
            vectors++;
            if (bus1.req_ready !== exp_rdy) begin
               miscompares++;
               $display("FAIL fair_ready[%0d.%0d]: got %b want %b", n, k, bus1.req_ready, exp_rdy);
            end
            if (k == 0) exp_d = ref_result(op_q[order[n]], a_q[order[n]], b_q[order[n]]);
            if (k == 3) begin
               vectors++;
               if ({bus1.resp_valid, bus1.resp_id, bus1.resp_data} !== {1'b1, ID_W'(order[n]), exp_d}) begin
                  miscompares++;
                  $display("FAIL fair_resp[%0d]: got rv=%0b id=%0d data=%h want rv=1 id=%0d data=%h",
                           n, bus1.resp_valid, bus1.resp_id, bus1.resp_data, order[n], exp_d);
               end
            end
            @(negedge clk);
            if (k == 0)
               set_req1(order[n], 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                        int'($urandom_range(0, 255)));
         end
      end
      clear_reqs();
      model_ptr = 2;
   endtask

   task automatic test_backpressure();
      logic [WIDTH:0] exp_d;
      test_single(1, 1'b0, 17, 250, 5);
      @(negedge clk);
      for (int i = 0; i < N_REQ; i++)
         set_req1(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      bus1.resp_ready = 1'b1;
      #1;
      vectors++;
      if (bus1.req_ready !== 4'b0100) begin
         miscompares++;
         $display("FAIL bp_next_grant: got %b want 0100", bus1.req_ready);
      end
      exp_d = ref_result(op_q[2], a_q[2], b_q[2]);
      @(negedge clk);
      clear_reqs();
      bus1.resp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      vectors++;
      if ({bus1.resp_valid, bus1.resp_id, bus1.resp_data} !== {1'b1, ID_W'(2), exp_d}) begin
         miscompares++;
         $display("FAIL bp_next_resp: got rv=%0b id=%0d data=%h want rv=1 id=2 data=%h",
                  bus1.resp_valid, bus1.resp_id, bus1.resp_data, exp_d);
      end
      @(negedge clk);
      #1;
      vectors++;
      if (bus1.resp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_next_drop: got rv=%0b want 0", bus1.resp_valid);
      end
      bus1.resp_ready = 1'b0;
      model_ptr = 3;
   endtask

   // Transaction-level scoreboard: random request arrivals and random
   // response backpressure, expected handshakes derived from the rules.
   task automatic test_random(input int ncyc);
      bit busy_m = 1'b0;
      bit exp_rv;
      int acc_cyc = 0;
      int gid = 0;
      int g;
      int drop_g = -1;
      int c = 0;
      logic [WIDTH:0] exp_d = '0;
      while ((c < ncyc || busy_m) && c < ncyc + 20) begin
         @(negedge clk);
         if (drop_g >= 0) begin
            bus1.req_valid[drop_g] = 1'b0;
            drop_g = -1;
         end
         if (c < ncyc) begin
            for (int i = 0; i < N_REQ; i++)
               if (!bus1.req_valid[i] && $urandom_range(0, 2) == 0)
                  set_req1(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                           int'($urandom_range(0, 255)));
            bus1.resp_ready = ($urandom_range(0, 2) != 0);
         end else begin
            bus1.req_valid  = '0;
            bus1.resp_ready = 1'b1;
         end
         #1;
         exp_rv = busy_m && (c - acc_cyc >= 3);
         vectors++;
         if (bus1.resp_valid !== exp_rv) begin
            miscompares++;
            $display("FAIL rand_resp_valid[c%0d]: got %0b want %0b", c, bus1.resp_valid, exp_rv);
         end
         if (exp_rv) begin
            vectors++;
            if ({bus1.resp_id, bus1.resp_data} !== {ID_W'(gid), exp_d}) begin
               miscompares++;
               $display("FAIL rand_resp_data[c%0d]: got id=%0d data=%h want id=%0d data=%h",
                        c, bus1.resp_id, bus1.resp_data, gid, exp_d);
            end
         end
         g = busy_m ? -1 : model_pick(bus1.req_valid);
         vectors++;
         if (bus1.req_ready !== onehot(g)) begin
            miscompares++;
            $display("FAIL rand_ready[c%0d]: got %b want %b", c, bus1.req_ready, onehot(g));
         end
         if (g >= 0) begin
            busy_m  = 1'b1;
            acc_cyc = c;
            gid     = g;
            exp_d   = ref_result(op_q[g], a_q[g], b_q[g]);
            drop_g  = g;
         end
         if (exp_rv && bus1.resp_ready) begin
            busy_m    = 1'b0;
            model_ptr = (gid + 1) % N_REQ;
         end
         c++;
      end
      if (busy_m) begin
         vectors++;
         miscompares++;
         $display("FAIL rand_drain_timeout: got busy after %0d cycles want idle", c);
      end
      bus1.resp_ready = 1'b0;
   endtask

   task automatic test_reset_midop();
      logic [WIDTH:0] exp_d;
      @(negedge clk);
      set_req1(1, 1'b0, 40, 50);
      @(negedge clk);
      bus1.req_valid = '0;
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      vectors++;
      if ({bus1.resp_valid, bus1.resp_id, bus1.resp_data, bus1.dp_load, bus1.dp_a, bus1.dp_b, bus1.busy} !== '0) begin
         miscompares++;
         $display("FAIL midop_reset_outputs: got rv=%0b id=%0d data=%h load=%0b a=%h b=%h busy=%0b want all 0",
                  bus1.resp_valid, bus1.resp_id, bus1.resp_data, bus1.dp_load, bus1.dp_a, bus1.dp_b, bus1.busy);
      end
      set_req1(1, 1'b1, 100, 30);
      set_req1(3, 1'b0, 7, 8);
      @(negedge clk);
      #1;
      vectors++;
      if ({bus1.req_ready, bus1.resp_valid} !== '0) begin
         miscompares++;
         $display("FAIL midop_held: got rdy=%b rv=%0b want 0 0", bus1.req_ready, bus1.resp_valid);
      end
      @(negedge clk);
      reset = 1'b1;
      model_ptr = 0;
      #1;
      vectors++;
      if (bus1.req_ready !== 4'b0010) begin
         miscompares++;
         $display("FAIL midop_grant: got %b want 0010", bus1.req_ready);
      end
      exp_d = ref_result(op_q[1], a_q[1], b_q[1]);
      @(negedge clk);
      clear_reqs();
      bus1.resp_ready = 1'b1;
      #1;
      vectors++;
      if (bus1.resp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL midop_stale: got rv=%0b want 0", bus1.resp_valid);
      end
      @(negedge clk);
      @(negedge clk);
      #1;
      vectors++;
      if ({bus1.resp_valid, bus1.resp_id, bus1.resp_data} !== {1'b1, ID_W'(1), exp_d}) begin
         miscompares++;
         $display("FAIL midop_resp: got rv=%0b id=%0d data=%h want rv=1 id=1 data=%h",
                  bus1.resp_valid, bus1.resp_id, bus1.resp_data, exp_d);
      end
      @(negedge clk);
      bus1.resp_ready = 1'b0;
      model_ptr = 2;
   endtask

   task automatic test_latency();
      logic exp_rv;
      @(negedge clk);
      bus3.req_valid = 4'b1000;
      bus3.req_op[3] = 1'b0;
      bus3.req_a[3*WIDTH +: WIDTH] = 8'd255;
      bus3.req_b[3*WIDTH +: WIDTH] = 8'd1;
      bus3.resp_ready = 1'b1;
      #1;
      vectors++;
      if (bus3.req_ready !== 4'b1000) begin
         miscompares++;
         $display("FAIL lat_ready: got %b want 1000", bus3.req_ready);
      end
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) bus3.req_valid = '0;
         #1;
         if (k == 1) begin
            vectors++;
            if ({bus3.dp_load, bus3.dp_a, bus3.dp_b} !== {1'b1, 8'd255, 8'd1}) begin
               miscompares++;
               $display("FAIL lat_load: got load=%0b a=%0d b=%0d want 1 255 1",
                        bus3.dp_load, bus3.dp_a, bus3.dp_b);
            end
         end
         exp_rv = (k == 5);
         vectors++;
         if (bus3.resp_valid !== exp_rv) begin
            miscompares++;
            $display("FAIL lat_valid[c+%0d]: got %0b want %0b", k, bus3.resp_valid, exp_rv);
         end
         if (k == 5) begin
            vectors++;
            if ({bus3.resp_id, bus3.resp_data} !== {ID_W'(3), 9'd256}) begin
               miscompares++;
               $display("FAIL lat_data: got id=%0d data=%0d want id=3 data=256",
                        bus3.resp_id, bus3.resp_data);
            end
         end
      end
      bus3.resp_ready = 1'b0;
   endtask

   initial begin
      clear_reqs();
      test_reset();
      test_fairness();
      test_single(0, 1'b0, 200, 100, 0);
      test_single(2, 1'b1, 5, 9, 0);
      test_backpressure();
      repeat (6)
         test_single(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
      test_random(300);
      test_reset_midop();
      test_latency();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion want finish before 200000");
      $fatal(1);
   end

endmodule
`default_nettype wire
